// File: rtl/dm_access_pkg.sv
// Shared types and constants for the data-memory access master and its lane aligner.
package dm_access_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

    // Offset of the last byte touched by an access of the given size.
    function automatic logic [1:0] last_offset(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational big-endian lane logic: extracts and extends a load lane from a
// memory word, and merges a sub-word store lane into the word read back.
module dm_lane_align
    import dm_access_pkg::*;
(
    input  logic [WORD_W-1:0] rword,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [HALF_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]        byte_shift;
    logic [4:0]        half_shift;
    logic [BYTE_W-1:0] byte_val;
    logic [HALF_W-1:0] half_val;

    // Byte at offset 0 is the most significant lane, so the shift is (3 - o) bytes.
    assign byte_shift = {~offset, 3'b000};
    assign half_shift = {~offset[1], 4'b0000};
    assign byte_val   = BYTE_W'(rword >> byte_shift);
    assign half_val   = HALF_W'(rword >> half_shift);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        load_data = rword;
        merged    = rword;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged    = (rword & ~(32'h0000_00FF << byte_shift))
                          | ({24'b0, wdata[7:0]} << byte_shift);
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
                merged    = (rword & ~(32'h0000_FFFF << half_shift))
                          | ({16'b0, wdata} << half_shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_master.sv
// Data-memory initiator: CPU byte/half/word loads and stores onto a big-endian word port,
// with read-modify-write for sub-word stores. Define DM_ACCESS_BOUNDS_CHECK_EN for range errors.
module dm_access_master
    import dm_access_pkg::*;
#(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [WORD_W-1:0] mem_rdata
);

    if (MEM_BYTES <= 0 || (MEM_BYTES % 4) != 0) begin : g_bad_mem_bytes
        $error("MEM_BYTES must be a positive multiple of 4");
    end

    state_e            state;
    state_e            next_state;
    size_e             size_q;
    logic [1:0]        offset_q;
    logic              write_q;
    logic              unsigned_q;
    logic [HALF_W-1:0] wdata_q;

    logic              accept;
    logic              illegal_size;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged_word;

    // NOTE: gating with rst_n makes req_ready drop the instant reset asserts, not at the next edge.
    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    assign illegal_size = (req_size == SZ_ILLEGAL);
    assign misaligned   = ((req_size == SZ_HALF) && req_addr[0])
                       || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef DM_ACCESS_BOUNDS_CHECK_EN
    logic [ADDR_W:0] last_byte;
    // One extra bit so an access wrapping past the top of the address space still flags.
    assign last_byte    = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, last_offset(req_size)};
    assign out_of_range = (last_byte >= (ADDR_W+1)'(MEM_BYTES));
`else
    assign out_of_range = 1'b0;
`endif

    assign req_err = illegal_size || misaligned || out_of_range;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = RESP;
                    else if (req_write && (req_size == SZ_WORD))
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:      next_state = write_q ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    dm_lane_align u_lane_align (
        .rword       (mem_rdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged_word)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            size_q     <= SZ_BYTE;
            offset_q   <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
        end else begin
            state     <= next_state;
            mem_write <= (next_state == WR);
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q     <= size_e'(req_size);
                        offset_q   <= req_addr[1:0];
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata[HALF_W-1:0];
                        resp_rdata <= '0;
                        resp_err   <= req_err;
                        if (!req_err)
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_err && req_write && (req_size == SZ_WORD))
                            mem_wdata <= req_wdata;
                    end
                end
                RD: begin
                    if (write_q)
                        mem_wdata <= merged_word;
                    else
                        resp_rdata <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_master.sv
// Self-checking bench for dm_access_master: byte-array memory model, per-cycle compare
// process and directed load/store/error/reset vectors with literal expectations.
module tb_dm_access_master;

    localparam int          MEM_BYTES = 32;
    localparam logic [31:0] W08       = 32'h1122_3344;
    localparam logic [31:0] W0C       = 32'h80FF_7F01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    dm_access_master #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        if (i / 4 == 2) return 8'(W08 >> (8 * (3 - i % 4)));
        if (i / 4 == 3) return 8'(W0C >> (8 * (3 - i % 4)));
        return 8'(i * 7 + 3);
    endfunction

    // Data memory: big-endian bytes, combinational read, write on the negedge of a strobe cycle.
    logic [7:0] dm_mem [MEM_BYTES];

    always_comb begin
        mem_rdata = '0;
        if (mem_addr < MEM_BYTES)
            mem_rdata = {dm_mem[mem_addr[4:0]],         dm_mem[mem_addr[4:0] + 5'd1],
                         dm_mem[mem_addr[4:0] + 5'd2],  dm_mem[mem_addr[4:0] + 5'd3]};
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) dm_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (mem_write && mem_addr < MEM_BYTES)
                {dm_mem[mem_addr[4:0]],        dm_mem[mem_addr[4:0] + 5'd1],
                 dm_mem[mem_addr[4:0] + 5'd2], dm_mem[mem_addr[4:0] + 5'd3]} = mem_wdata;
        end
    end

    // Reference model state and the expectation for the transaction in flight.
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        exp_active = 1'b0;
    int          exp_lat = 0;
    int          exp_writes = 0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_waddr = '0;
    logic [31:0] exp_wword = '0;

    int cyc = 0;
    int wr_count = 0;
    int first_valid = -1;

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return (a < MEM_BYTES) ? ref_mem[a[4:0]] : 8'h00;
    endfunction

    // Compare process: cycles are counted as posedges since the accepting edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!(rst_n && exp_active)) begin
                cyc = 0;
                wr_count = 0;
                first_valid = -1;
            end else begin
                cyc++;
                check("req_ready_busy", req_ready, 0);
                check("resp_valid_timing", resp_valid, (cyc >= exp_lat) ? 1 : 0);
                if (resp_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    check("resp_rdata", resp_rdata, exp_rdata);
                    check("resp_err", resp_err, exp_err);
                end
                if (cyc == 1 && !exp_err) check("mem_addr", mem_addr, exp_waddr);
                if (mem_write) begin
                    wr_count++;
                    check("mem_write_addr", mem_addr, exp_waddr);
                    check("mem_write_data", mem_wdata, exp_wword);
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
        int          nbytes;
        int          n;
        logic        err;
        logic [31:0] val;
        logic [31:0] wa;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
`ifdef DM_ACCESS_BOUNDS_CHECK_EN
        if (64'(addr) + 64'(nbytes) - 64'd1 >= 64'(MEM_BYTES)) err = 1'b1;
`endif
        wa         = {addr[31:2], 2'b00};
        exp_err    = err;
        exp_waddr  = wa;
        exp_lat    = err ? 1 : (!wr) ? 2 : (nbytes == 4) ? 2 : 3;
        exp_writes = (!err && wr) ? 1 : 0;
        exp_rdata  = '0;
        if (!err && !wr) begin
            val = '0;
            for (int k = 0; k < nbytes; k++) val = (val << 8) | 32'(ref_byte(addr + 32'(k)));
            if (!uns && nbytes == 1 && val[7])  val = val | 32'hFFFF_FF00;
            if (!uns && nbytes == 2 && val[15]) val = val | 32'hFFFF_0000;
            exp_rdata = val;
        end
        if (!err && wr) begin
            for (int k = 0; k < nbytes; k++)
                if (addr + 32'(k) < MEM_BYTES)
                    ref_mem[5'(addr + 32'(k))] = 8'(wd >> (8 * (nbytes - 1 - k)));
            exp_wword = {ref_byte(wa), ref_byte(wa + 1), ref_byte(wa + 2), ref_byte(wa + 3)};
        end

        @(posedge clk); #1;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~wr; req_size = ~sz; req_unsigned = ~uns;
        req_addr = ~addr; req_wdata = ~wd;
        exp_active = 1'b1;

        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("resp_valid_seen", resp_valid, 1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        got_rdata  = resp_rdata;
        got_err    = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("latency", first_valid, exp_lat);
        check("mem_write_count", wr_count, exp_writes);
        check("resp_valid_dropped", resp_valid, 0);
        check("req_ready_after", req_ready, 1);
        exp_active = 1'b0;
    endtask

    task automatic reset_mid(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mem_write_before_reset", mem_write, wr);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mem_write", mem_write, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after_reset", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);

        #2;
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_err", resp_err, 0);
        check("reset_resp_rdata", resp_rdata, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_mem_write", mem_write, 0);
        check("reset_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("ready_after_release", req_ready, 1);

        do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'hDEAD_BEEF, 0, r, e);
        check("sw_err", e, 0);
        check("dm_byte4", dm_mem[4], 8'hDE);
        check("dm_byte5", dm_mem[5], 8'hAD);
        check("dm_byte6", dm_mem[6], 8'hBE);
        check("dm_byte7", dm_mem[7], 8'hEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0, r, e);
        check("lw_04", r, 32'hDEAD_BEEF);

        do_req(1'b1, 2'd0, 1'b0, 32'h0A, 32'h0000_00AA, 1, r, e);
        check("sb_word08", {dm_mem[8], dm_mem[9], dm_mem[10], dm_mem[11]}, 32'h1122_AA44);
        check("sb_rdata", r, 0);

        do_req(1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, 0, r, e);
        check("lb_0c", r, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h0C, 32'h0, 0, r, e);
        check("lbu_0c", r, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 0, r, e);
        check("lh_0e", r, 32'h0000_7F01);
        do_req(1'b0, 2'd1, 1'b0, 32'h0C, 32'h0, 0, r, e);
        check("lh_0c", r, 32'hFFFF_80FF);
        do_req(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 0, r, e);
        check("lbu_0b", r, 32'h0000_0044);

        do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 3, r, e);
        check("lh_05_err", e, 1);
        check("lh_05_rdata", r, 0);
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h1234_5678, 3, r, e);
        check("sw_06_err", e, 1);
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0, r, e);
        check("size3_err", e, 1);

        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_ABCD, 0, r, e);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, r, e);
        check("lhu_12", r, 32'h0000_ABCD);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 2, r, e);
        check("lh_12", r, 32'hFFFF_ABCD);
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFF_FF5A, 0, r, e);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e);

        do_req(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 0, r, e);
        check("lw_1c_err", e, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, r, e);
`ifdef DM_ACCESS_BOUNDS_CHECK_EN
        check("lw_20_err", e, 1);
`else
        check("lw_20_err", e, 0);
`endif

        reset_mid(1'b0, 32'h0C, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 0, r, e);
        check("lw_0c_after_reset", r, 32'h80FF_7F01);
        reset_mid(1'b1, 32'h00, 32'hCAFE_F00D);
        do_req(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0, r, e);

        for (int i = 0; i < MEM_BYTES; i++) check("dm_vs_model", dm_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
